// File: rtl/otter_rf_pkg.sv
// Shared defaults and helpers for the OTTER register file with scoreboard.
package otter_rf_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_NRD   = 2;
  localparam int unsigned DEF_CNT_W = 2;

  localparam int unsigned X0 = 0;

  // Saturation value of a w-bit pending-write counter.
  function automatic int unsigned cnt_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/otter_sb_counter.sv
// Per-register pending-write counter: saturates at its maximum, never underflows,
// and holds its value when an issue and a retire land on the same edge.
module otter_sb_counter
  import otter_rf_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic do_inc;
  logic do_dec;

  assign full   = (cnt == MAX);
  assign do_inc = inc && !full;
  // A retire with nothing outstanding is an unscheduled write: count stays 0.
  assign do_dec = dec && (cnt != '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (do_inc && !do_dec) begin
      cnt <= cnt + 1'b1;
    end else if (do_dec && !do_inc) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/otter_regfile_sb.sv
// OTTER register file with optional write-through bypass and a pending-write
// scoreboard; read ports report busy so decode can stall on RAW hazards.
module otter_regfile_sb
  import otter_rf_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NRD    = DEF_NRD,
  parameter int unsigned BYPASS = 1,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NRD*AW-1:0]   RF_ADR,
  output logic [NRD*XLEN-1:0] RF_RS,
  output logic [NRD-1:0]      RF_BUSY,
  input  logic [AW-1:0]       RF_WA,
  input  logic [XLEN-1:0]     RF_WD,
  input  logic                RF_EN,
  input  logic                SB_SET,
  input  logic [AW-1:0]       SB_RD,
  output logic                SB_FULL,
  output logic                SB_OVF
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0][CNT_W-1:0] cnt;
  logic [NREGS-1:0]            full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RF_EN && (RF_WA != AW'(X0))) begin
      regs[RF_WA] <= RF_WD;
    end
  end

  // x0 has no counter: it is never busy and never full.
  assign cnt[0]  = '0;
  assign full[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_sb
    logic inc;
    logic dec;

    assign inc = SB_SET && (SB_RD == AW'(r));
    assign dec = RF_EN && (RF_WA == AW'(r));

    otter_sb_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .CLK (CLK),
      .RST (RST),
      .inc (inc),
      .dec (dec),
      .cnt (cnt[r]),
      .full(full[r])
    );
  end

  assign SB_FULL = full[SB_RD];

  always_ff @(posedge CLK) begin
    if (RST) begin
      SB_OVF <= 1'b0;
    end else if (SB_SET && SB_FULL) begin
      SB_OVF <= 1'b1;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0] adr;
    logic          hit;

    assign adr = RF_ADR[p*AW +: AW];
    assign hit = (BYPASS != 0) && RF_EN && (RF_WA == adr);

    always_comb begin
      RF_RS[p*XLEN +: XLEN] = '0;
      RF_BUSY[p]            = 1'b0;
      if (adr != AW'(X0)) begin
        if (hit) begin
          // The write landing this edge retires one pending write already.
          RF_RS[p*XLEN +: XLEN] = RF_WD;
          RF_BUSY[p]            = (cnt[adr] > CNT_W'(1));
        end else begin
          RF_RS[p*XLEN +: XLEN] = regs[adr];
          RF_BUSY[p]            = (cnt[adr] != '0);
        end
      end
    end
  end

endmodule

// File: doc/otter_regfile_sb.md
# otter_regfile_sb

Parametrised OTTER register file with write-through bypass and a per-register pending-write scoreboard. It serves the pipelined OTTER core. Read ports present architectural or bypassed data together with a busy indication, so decode can stall on RAW hazards without a separate hazard unit. Register 0 is hardwired to zero and never busy.

## Interface
Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, register count; power of two, at least 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- CNT_W, 2, width of each per-register pending-write counter.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- RF_ADR  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- RF_RS  out  NRD*XLEN  read data, combinational.
- RF_BUSY  out  NRD  per-port pending-write flag of the addressed register, combinational.
- RF_WA  in  AW  write/retire address.
- RF_WD  in  XLEN  write data.
- RF_EN  in  1  write enable; also retires one pending write on RF_WA.
- SB_SET  in  1  issue strobe; marks SB_RD as having one more write in flight.
- SB_RD  in  AW  destination register of the issuing instruction.
- SB_FULL  out  1  combinational; the SB_RD counter is at max and a set would overflow.
- SB_OVF  out  1  sticky error flag; set when SB_SET is applied while SB_FULL=1.

## Operation
- Storage: NREGS x XLEN array, plus NREGS x CNT_W counters cnt[r].
- Write: on a clock edge with RF_EN=1 and RF_WA≠0, reg[RF_WA] <= RF_WD. Writes to register 0 are discarded.
- Read port i, address a:
  - a=0 gives 0.
  - Otherwise, if BYPASS=1, RF_EN=1 and RF_WA=a, gives RF_WD.
  - Otherwise gives reg[a].
- RF_BUSY[i]:
  - a=0 gives 0.
  - With a bypass hit, RF_BUSY[i] = (cnt[a] > 1).
  - Otherwise RF_BUSY[i] = (cnt[a] ≠ 0).
- Scoreboard update per edge, with register r:
  - inc = SB_SET and SB_RD=r and r≠0 and not SB_FULL.
  - dec = RF_EN and RF_WA=r and r≠0 and cnt[r]≠0.
  - inc only: cnt+1. dec only: cnt-1. Both or neither: unchanged.
- Retire with cnt=0 (unscheduled write): data is written, the counter stays 0, and no error is raised.
- SB_FULL = SB_RD≠0 and cnt[SB_RD] = 2^CNT_W-1.
- Set while full: the counter is unchanged and SB_OVF <= 1.
- SB_OVF clears only on RST.
- When SB_RD=0, SB_SET has no effect and never flags overflow.

## Timing
- Read and busy outputs: zero-cycle, combinational from addresses, RF_EN, RF_WA, RF_WD and state.
- Write: visible through the array one edge after RF_EN. With BYPASS it is also visible in the same cycle.
- Issue: SB_SET at edge n makes RF_BUSY for that register 1 from cycle n+1.
- RST=1 at an edge clears all registers to 0, all cnt to 0 and SB_OVF to 0. RST has priority over any simultaneous write or set.
- After reset: RF_RS=0 and RF_BUSY=0 on every port, SB_FULL=0, SB_OVF=0.
- Reset mid-operation discards all in-flight scoreboard state. The core must flush its pipeline with it.
- Simultaneous SB_SET and RF_EN on the same register within one cycle leave the count unchanged. Bypassed data is still forwarded that cycle.

## Structure
- Package otter_rf_pkg holds:
  - default XLEN, NREGS, NRD and CNT_W;
  - localparam X0 = 0;
  - a function for the saturating max value (2^CNT_W-1).
- Sub-module otter_sb_counter: one CNT_W up/down counter with inc, dec, rst and full. It is generated NREGS-1 times; register 0 has none.
- The read path is a generate loop over NRD ports in the top module.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert RST for 1 cycle -> x5 reads 0, all RF_BUSY=0, SB_OVF=0.
- x0: RF_EN=1, RF_WA=0, RF_WD=0x1234; SB_SET with SB_RD=0 -> x0 reads 0, RF_BUSY=0, counters unchanged.
- Bypass: x8=0x11 stored, then RF_EN=1, RF_WA=8, RF_WD=0x22, both ports read x8 -> 0x22 the same cycle, and 0x22 after the edge with RF_EN=0. With BYPASS=0 -> 0x11 the same cycle.
- Scoreboard: SB_SET x10 twice (cnt=2) -> RF_BUSY=1. One retire -> still 1. Bypassed retire while cnt=1 -> RF_BUSY=0 that cycle, and cnt=0 after.
- Simultaneous: cnt[x12]=1, SB_SET x12 and RF_EN x12 in the same cycle -> cnt stays 1, reg[12] updated.
- Overflow: with CNT_W=2, SB_SET x13 three times -> SB_FULL=1. A fourth set -> cnt stays 3, SB_OVF=1 and held until RST.
